// File: rtl/inst_fetch_pkg.sv
// Shared fetch/decode constants: NOP encoding, reset PC default, opcodes and the JAL immediate decoder.
package inst_fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] jal_imm(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with single-cycle flush; head is visible combinationally on o_dout.
// Push while full is accepted only when a pop happens the same cycle; flush overrides push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/inst_fetch.sv
// Sequential-PC fetch stage: credit-limited imem requests, in-order response queue, redirect flush.
// Head-of-queue to decode with zero added latency; optional JAL self-redirect under FETCH_JAL_PREDICT_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  fetch_entry_t  w_head;
  fetch_entry_t  w_q_din;
  logic          w_q_empty;
  logic          w_q_full;
  logic [CW-1:0] w_q_count;
  logic [31:0]   w_tag_pc;
  logic          w_tag_empty;
  logic          w_tag_full;
  logic [CW-1:0] w_tag_count;

  logic [CW:0]   w_inflight;
  logic          w_issue;
  logic          w_rsp_keep;
  logic          w_pop;
  logic          w_jal_take;
  logic [31:0]   w_jal_pc;
  logic          w_redir;
  logic [31:0]   w_next_pc;

  assign inst_valid = !w_q_empty;
  assign inst       = inst_valid ? w_head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? w_head.pc : 32'h0;

`ifdef FETCH_JAL_PREDICT_EN
  assign w_jal_take = inst_valid && inst_ready && !redirect_valid && (inst[6:0] == OPC_JAL);
  assign w_jal_pc   = inst_pc + jal_imm(inst);
`else
  assign w_jal_take = 1'b0;
  assign w_jal_pc   = 32'h0;
`endif

  // External redirect beats a predicted JAL; either one flushes everything younger.
  assign w_redir   = redirect_valid || w_jal_take;
  assign w_next_pc = (redirect_valid ? redirect_pc : w_jal_pc) & 32'hFFFF_FFFC;

  // Credits cover both in-flight requests (including ones to be discarded) and queued entries.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_q_count};
  assign imem_req   = rst_n && !w_redir && (w_inflight < CREDITS);
  assign imem_addr  = r_pc;
  assign w_issue    = imem_req && imem_ready;

  assign w_rsp_keep = imem_rvalid && (r_discard == '0) && !w_redir;
  assign w_pop      = inst_valid && inst_ready && !w_redir;
  assign w_q_din    = '{inst: imem_rdata, pc: w_tag_pc};

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_inst_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_redir),
    .i_push  (w_rsp_keep),
    .i_din   (w_q_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_redir),
    .i_push  (w_issue),
    .i_din   (r_pc),
    .i_pop   (w_rsp_keep),
    .o_dout  (w_tag_pc),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(imem_rvalid);
      if (w_redir) begin
        // Every request still in flight after this edge belongs to the old path.
        r_pc      <= w_next_pc;
        r_discard <= r_outstanding - CW'(imem_rvalid);
      end else begin
        if (w_issue) r_pc <= r_pc + 32'd4;
        if (imem_rvalid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      end
    end
  end

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (r_outstanding != '0));
  a_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
    w_rsp_keep |-> !w_tag_empty);
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    w_issue |-> !w_tag_full);
  a_tag_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    w_tag_count <= r_outstanding);
  a_q_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    w_rsp_keep |-> (!w_q_full || w_pop));

endmodule
